// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with majority-vote sampling, FWFT byte FIFO and sticky error flags
module uart_rx_fifo_q #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [7:0]  wdata,
    input  logic        rd,
    output logic [7:0]  rdata,
    output logic        valid,
    output logic [AW:0] level,
    output logic        drop
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        full, do_pop, do_push;

    assign level   = wp - rp;
    assign valid   = (wp != rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = rd && valid;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign do_push = wr && (!full || do_pop);
    assign drop    = wr && full && !do_pop;
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= wdata;
                wp              <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

module uart_rx_fifo #(
    parameter int  FREQ_MHZ = 12,
    parameter int  BAUDS    = 115200,
    parameter int  DEPTH    = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        rd,
    output logic [7:0]  rx_data,
    output logic        valid,
    output logic [AW:0] level,
    output logic        frame_err,
    output logic        overrun,
    input  logic        clr_err
);
    localparam int DIV = FREQ_MHZ * 1000000 / BAUDS;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] C_S0   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(DIV / 2);
    localparam logic [CW-1:0] C_DEC  = CW'(DIV / 2 + 1);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic          rx_meta, rs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          s0, s1, maj, decide;
    logic          push, ferr_set, drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    // Third vote is the live sample at the decision count.
    assign maj    = (s0 & s1) | (s0 & rs) | (s1 & rs);
    assign decide = (cnt == C_DEC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            s0    <= 1'b1;
            s1    <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            if (cnt == C_S0) s0 <= rs;
            if (cnt == C_S1) s1 <= rs;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rs) state_n = IDLE;
            end
            IDLE: begin
                cnt_n = '0;
                if (!rs) state_n = START;
            end
            START: begin
                cnt_n = cnt + 1'b1;
                if (decide && maj) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == C_LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            DATA: begin
                cnt_n = cnt + 1'b1;
                if (decide) shreg_n = {maj, shreg[7:1]};
                if (cnt == C_LAST) begin
                    cnt_n = '0;
                    idx_n = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                cnt_n = cnt + 1'b1;
                // Leave at mid-stop so a start bit in the late half is not missed.
                if (decide) begin
                    cnt_n = '0;
                    if (maj) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = WAIT_HIGH;
                    end
                end
            end
            default: state_n = WAIT_HIGH;
        endcase
    end

    uart_rx_fifo_q #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push),
        .wdata (shreg),
        .rd    (rd),
        .rdata (rx_data),
        .valid (valid),
        .level (level),
        .drop  (drop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (drop)         overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int DIV    = 104;
    localparam int FRAME  = 10 * DIV;
    localparam int PUSH_I = 9 * DIV + DIV / 2 + 4;

    logic       clk = 1'b0;
    logic       reset, rx, rd, clr_err;
    logic [7:0] rx_data;
    logic       valid, frame_err, overrun;
    logic [4:0] level;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       m_ferr, m_ovr;

    uart_rx_fifo #(.FREQ_MHZ(12), .BAUDS(115200), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .rx_data   (rx_data),
        .valid     (valid),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(q.size()));
        chk({tag, "_valid"}, 32'(valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, "_head"}, 32'(rx_data), 32'(q[0]));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
            rd = 1'b0;
        end
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        chk({tag, "_pop_valid"}, 32'(valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, "_pop_data"}, 32'(rx_data), 32'(q[0]));
            void'(q.pop_front());
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One frame; optional stop-bit fault, mid-bit spikes, and a pop aligned to the push.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit spike, input bit pop_at_push);
        logic bitv;
        int   slot;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            slot = i / DIV;
            bitv = (slot == 0) ? 1'b0 : (slot == 9) ? stop_ok : b[slot-1];
            if (spike && (i % DIV) == DIV / 2 + 1) bitv = ~bitv;
            rx = bitv;
            rd = pop_at_push && (i == PUSH_I);
        end
        if (!stop_ok) m_ferr = 1'b1;
        else begin
            if (pop_at_push && q.size() != 0) void'(q.pop_front());
            if (q.size() == DEPTH) m_ovr = 1'b1;
            else q.push_back(b);
        end
    endtask

    initial begin
        logic [7:0] rb;
        reset = 1'b1; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        check_state("reset");
        reset = 1'b0;
        idle(10);

        send_frame(8'hA5, 1, 0, 0);
        check_state("t1");
        pop_one("t1");
        check_state("t1_after_pop");

        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, 0, 0);
        check_state("t2_full");
        clear_errs();
        check_state("t2_clr");

        send_frame(8'h11, 1, 0, 1);
        check_state("t3_pushpop");
        for (int i = 0; i < DEPTH; i++) pop_one("t3_drain");
        check_state("t3_empty");

        idle(10);
        repeat (20) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(200);
        check_state("t4_glitch");
        send_frame(8'h3C, 1, 0, 0);
        check_state("t4_frame");

        send_frame(8'h55, 0, 0, 0);
        repeat (3 * FRAME) begin
            @(negedge clk);
            rx = 1'b0;
        end
        check_state("t5_break");
        idle(50);
        send_frame(8'h81, 1, 0, 0);
        check_state("t5_after");
        clear_errs();
        check_state("t5_clr");

        send_frame(8'h6E, 1, 1, 0);
        check_state("t6_spike");

        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        reset = 1'b1;
        #1;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_state("t6_in_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (FRAME + 300) @(negedge clk);
        chk("t6_low_level", 32'(level), 32'h0);
        chk("t6_low_valid", 32'(valid), 32'h0);
        idle(20);
        clear_errs();
        send_frame(8'h9B, 1, 0, 0);
        check_state("t6_new_frame");
        pop_one("t6");

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            idle($urandom_range(0, 20));
            send_frame(rb, 1, 0, 0);
            check_state("rand");
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_one("rand");
        end
        while (q.size() != 0) pop_one("final");
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
